// File: rtl/exibidor_sequencia.sv
// Shows the stored colour sequence on the LEDs, entry 0 up to the captured round.
// Optional macro EXIBE_PAUSA_INICIAL_EN adds a dark pause before the first entry.
module exibidor_sequencia #(
    parameter int unsigned T_ACESO   = 1000,
    parameter int unsigned T_APAGADO = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] rodada,
    input  logic [3:0] mem_dado,
    output logic [3:0] mem_endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int unsigned TW = 16;
    localparam int unsigned AW = 4;
    localparam logic [TW-1:0] ACESO_ULT   = TW'(T_ACESO - 1);
    localparam logic [TW-1:0] APAGADO_ULT = TW'(T_APAGADO - 1);

    typedef enum logic [3:0] {
        OCIOSO  = 4'h0,
`ifdef EXIBE_PAUSA_INICIAL_EN
        PAUSA   = 4'h1,
`endif
        ACESO   = 4'h2,
        APAGADO = 4'h3,
        FIM     = 4'h4
    } estado_t;

    estado_t        estado_q, estado_d;
    logic [AW-1:0]  endereco_q, endereco_d;
    logic [AW-1:0]  ultimo_q, ultimo_d;
    logic [TW-1:0]  timer_q, timer_d;

    // State and data-path registers
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= '0;
            ultimo_q   <= '0;
            timer_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            ultimo_q   <= ultimo_d;
            timer_q    <= timer_d;
        end
    end

    // Next-state, timer/address update and LED drive
    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        ultimo_d   = ultimo_q;
        timer_d    = timer_q;
        leds       = '0;
        unique case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    endereco_d = '0;
                    ultimo_d   = rodada;
                    timer_d    = '0;
`ifdef EXIBE_PAUSA_INICIAL_EN
                    estado_d   = PAUSA;
`else
                    estado_d   = ACESO;
`endif
                end
            end
`ifdef EXIBE_PAUSA_INICIAL_EN
            PAUSA: begin
                if (timer_q == APAGADO_ULT) begin
                    timer_d  = '0;
                    estado_d = ACESO;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif
            ACESO: begin
                leds = mem_dado;
                if (timer_q == ACESO_ULT) begin
                    timer_d  = '0;
                    estado_d = APAGADO;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            APAGADO: begin
                if (timer_q == APAGADO_ULT) begin
                    timer_d = '0;
                    // Address only advances here, so it is stable for a whole lit interval
                    if (endereco_q == ultimo_q) begin
                        estado_d = FIM;
                    end else begin
                        endereco_d = endereco_q + AW'(1);
                        estado_d   = ACESO;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign mem_endereco = endereco_q;
    assign ocupado      = (estado_q != OCIOSO);
    assign pronto       = (estado_q == FIM);
    assign db_estado    = estado_q;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Randomized self-checking bench for exibidor_sequencia against a cycle-offset model.
module tb_exibidor_sequencia;

    localparam int unsigned TA = 4;
    localparam int unsigned TP = 2;
    localparam int unsigned PER = TA + TP;
`ifdef EXIBE_PAUSA_INICIAL_EN
    localparam int unsigned PRE = TP;
`else
    localparam int unsigned PRE = 0;
`endif

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] rodada;
    logic [3:0] mem_dado;
    logic [3:0] mem_endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] mem [16];
    int n_checks;
    int n_pass;

    exibidor_sequencia #(.T_ACESO(TA), .T_APAGADO(TP)) dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .rodada(rodada),
        .mem_dado(mem_dado),
        .mem_endereco(mem_endereco),
        .leds(leds),
        .ocupado(ocupado),
        .pronto(pronto),
        .db_estado(db_estado)
    );

    assign mem_dado = mem[mem_endereco];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected outputs t cycles after the accepting edge, for a run of r+1 entries
    task automatic model_at(input int t, input int r,
                            output logic [3:0] e_leds, output logic [3:0] e_addr,
                            output logic [3:0] e_est, output logic e_ocup, output logic e_pr);
        int u;
        e_leds = 4'h0; e_addr = 4'h0; e_est = 4'h0; e_ocup = 1'b0; e_pr = 1'b0;
        if (t - 1 < int'(PRE)) begin
            e_est = 4'h1; e_ocup = 1'b1;
        end else begin
            u = t - 1 - int'(PRE);
            if (u < (r + 1) * int'(PER)) begin
                e_addr = 4'(u / int'(PER));
                e_ocup = 1'b1;
                if (u % int'(PER) < int'(TA)) begin
                    e_est  = 4'h2;
                    e_leds = mem[u / int'(PER)];
                end else begin
                    e_est = 4'h3;
                end
            end else if (u == (r + 1) * int'(PER)) begin
                e_addr = 4'(r); e_est = 4'h4; e_ocup = 1'b1; e_pr = 1'b1;
            end else begin
                e_addr = 4'(r);
            end
        end
    endtask

    task automatic check_cycle(input int t, input int r);
        logic [3:0] el, ea, ee;
        logic eo, ep;
        model_at(t, r, el, ea, ee, eo, ep);
        check_eq("leds", leds, el);
        check_eq("mem_endereco", mem_endereco, ea);
        check_eq("db_estado", db_estado, ee);
        check_eq("ocupado", 4'(ocupado), 4'(eo));
        check_eq("pronto", 4'(pronto), 4'(ep));
    endtask

    // Start at the next edge, then check every cycle through the first idle cycle
    task automatic run_seq(input int r, input bit interfere);
        int total;
        total = int'(PRE) + (r + 1) * int'(PER) + 2;
        rodada  = 4'(r);
        iniciar = 1'b1;
        @(posedge clock); #1;
        iniciar = 1'b0;
        for (int t = 1; t <= total; t++) begin
            check_cycle(t, r);
            if (interfere && t == 5) begin
                rodada  = 4'h0;
                iniciar = 1'b1;
            end else if (interfere && t == 6) begin
                iniciar = 1'b0;
            end
            if (t < total) begin
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) mem[i] = 4'(1 << $urandom_range(0, 3));
    endtask

    initial begin
        int stop_t;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        iniciar  = 1'b0;
        rodada   = 4'h0;
        fill_random();
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;

        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_leds", leds, 4'h0);
        check_eq("rst_addr", mem_endereco, 4'h0);
        check_eq("rst_ocupado", 4'(ocupado), 4'h0);
        check_eq("rst_pronto", 4'(pronto), 4'h0);
        check_eq("rst_estado", db_estado, 4'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        run_seq(0, 1'b0);
        run_seq(3, 1'b1);
        fill_random();
        run_seq(15, 1'b0);

        // Reset while entry 2 is lit aborts without pronto
        rodada  = 4'h5;
        iniciar = 1'b1;
        @(posedge clock); #1;
        iniciar = 1'b0;
        stop_t = int'(PRE) + 2 * int'(PER) + 1;
        for (int t = 1; t <= stop_t; t++) begin
            check_cycle(t, 5);
            if (t < stop_t) begin
                @(posedge clock); #1;
            end
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_eq("abort_leds", leds, 4'h0);
        check_eq("abort_addr", mem_endereco, 4'h0);
        check_eq("abort_estado", db_estado, 4'h0);
        check_eq("abort_ocupado", 4'(ocupado), 4'h0);
        for (int i = 0; i < 40; i++) begin
            check_eq("abort_no_pronto", 4'(pronto), 4'h0);
            @(posedge clock); #1;
        end
        run_seq(0, 1'b0);

        for (int n = 0; n < 6; n++) begin
            fill_random();
            run_seq(int'($urandom_range(0, 7)), n[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/exibidor_sequencia.md
# exibidor_sequencia

Presents the stored colour sequence of the memory game on the four LEDs before each player round. It reads the sequence RAM from address 0 up to the current round index and lights each entry for a fixed on-time followed by a dark gap. It is the output-side counterpart of the button/compare path and sits beside the game data path. The control unit starts it and waits for `pronto`, and its `leds` are OR-ed with the button echo at top level.

## Interface
Parameters:
- `T_ACESO`, default 1000: cycles each sequence entry is lit; legal range 1..65535.
- `T_APAGADO`, default 500: cycles of dark gap after each entry; legal range 1..65535.

Ports:
- `clock` input 1: single system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `iniciar` input 1: start request; sampled only in OCIOSO.
- `rodada` input 4: index of the last entry to show, 0..15; captured when start is accepted.
- `mem_dado` input 4: RAM read data; asynchronous-read RAM, valid in the same cycle as `mem_endereco`.
- `mem_endereco` output 4: RAM read address (registered).
- `leds` output 4: LED drive; one-hot colour from RAM while lit, 0000 otherwise.
- `ocupado` output 1: high in every state except OCIOSO.
- `pronto` output 1: one-cycle pulse when the sequence is complete.
- `db_estado` output 4: state code for the hex debug display.

## Operation
- State codes: OCIOSO=4'h0, PAUSA=4'h1, ACESO=4'h2, APAGADO=4'h3, FIM=4'h4.
- Internal registers:
  - `endereco` (4b), drives `mem_endereco`.
  - `ultimo` (4b), the captured `rodada`.
  - `timer` (16b), counts cycles spent in the current state.
- OCIOSO:
  - `leds`=0.
  - On `iniciar`=1: `endereco`←0, `ultimo`←`rodada`, `timer`←0, then go to ACESO (or to PAUSA, see Configuration).
  - Otherwise stay in OCIOSO.
- ACESO:
  - `leds`=`mem_dado` (combinational from state and RAM output).
  - `timer` increments each cycle. When `timer`==T_ACESO−1: `timer`←0, go to APAGADO.
- APAGADO:
  - `leds`=0; `timer` increments each cycle.
  - When `timer`==T_APAGADO−1, `timer`←0, then:
    - if `endereco`==`ultimo`: go to FIM;
    - else `endereco`←`endereco`+1 and go to ACESO.
- FIM: `pronto`=1 for exactly this one cycle, `leds`=0, then go to OCIOSO. `endereco` is held.
- `iniciar` is ignored in every state other than OCIOSO. Changes to `rodada` after capture are ignored.
- `endereco` never wraps: `ultimo`≤15 guarantees the last increment lands at most at 15.
- Reset behaviour:
  - Reset at any time: on the next edge, state=OCIOSO, `endereco`=0, `ultimo`=0, `timer`=0.
  - Reset has priority over `iniciar`.
  - Reset mid-sequence aborts it with no `pronto` pulse.
- Reset values: `leds`=0000, `mem_endereco`=0000, `ocupado`=0, `pronto`=0, `db_estado`=4'h0.

## Timing
- Start: `iniciar` is high at edge k while in OCIOSO. From cycle k+1 the block is in ACESO with `ocupado`=1 and `leds`=mem[0] (no PAUSA).
- Each entry i: lit for exactly T_ACESO cycles, then dark for exactly T_APAGADO cycles. The address changes only on the APAGADO→ACESO edge, so it is stable for the entire lit interval.
- Total busy time for `rodada`=r: (r+1)·(T_ACESO+T_APAGADO) cycles, plus 1 FIM cycle. `pronto` is asserted in cycle k+1+(r+1)·(T_ACESO+T_APAGADO).
- `pronto` and `ocupado` are both high in the FIM cycle. `ocupado` falls on the next cycle.
- A new `iniciar` can be accepted on the first OCIOSO cycle after FIM (back-to-back restart).
- `leds` has zero cycles of latency relative to state and `mem_dado`. Its glitch-freedom relies on the RAM's output being stable for a fixed address.

## Configuration
- `EXIBE_PAUSA_INICIAL_EN` defined:
  - An accepted start goes to PAUSA instead of ACESO.
  - PAUSA: `leds`=0, `ocupado`=1, lasts T_APAGADO cycles, then `timer`←0 and go to ACESO.
  - Total busy time grows by T_APAGADO, and all other timing shifts by the same amount.
- Not defined: the PAUSA state and its code are absent; OCIOSO goes directly to ACESO. Code 4'h1 never appears on `db_estado`.

## Test plan
All scenarios use T_ACESO=4, T_APAGADO=2, with RAM contents mem[0..3]=0001,0010,0100,1000.
- Reset: hold `reset` 2 cycles → `leds`=0000, `mem_endereco`=0, `ocupado`=0, `pronto`=0, `db_estado`=0.
- `rodada`=0, `iniciar` pulse at edge k (macro off) → `leds`=0001 for cycles k+1..k+4, 0000 for k+5..k+6; `pronto`=1 at k+7 only; `ocupado` falls at k+8.
- `rodada`=3 → `leds` shows 0001, 0010, 0100, 1000, each for 4 cycles separated by 2-cycle gaps; `pronto` at k+25. During the run, `rodada` is changed to 0 and `iniciar` is pulsed again; neither has any effect.
- `rodada`=15 with all 16 RAM words loaded → `mem_endereco` steps 0..15, never reaches 0 again before FIM; `pronto` at k+97.
- `reset` asserted while in ACESO at entry 2 → next cycle OCIOSO, `leds`=0000, `mem_endereco`=0, no `pronto`. A following `iniciar` restarts from mem[0].
- Macro on, `rodada`=0 → `db_estado`=1 and `leds`=0000 for cycles k+1..k+2; `leds`=0001 for k+3..k+6; `pronto` at k+9.
